// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the iterative multiplier
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/mul_cneg.sv
// rtl/mul_cneg.sv - combinational conditional two's-complement negate
module mul_cneg #(
    parameter int WIDTH = 32
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = neg_i ? ({WIDTH{1'b0}} - data_i) : data_i;

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, full signed/unsigned product
// Optional MUL_EARLY_OUT_EN: leave CALC once the remaining multiplier bits are zero.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 done_q, done_d;
    logic                 calc_last;

    // The loop works on magnitudes; the sign is reapplied once to the full product.
    mul_cneg #(.WIDTH(WIDTH)) u_mag_a (
        .neg_i  (is_signed & a[WIDTH-1]),
        .data_i (a),
        .data_o (a_mag)
    );

    mul_cneg #(.WIDTH(WIDTH)) u_mag_b (
        .neg_i  (is_signed & b[WIDTH-1]),
        .data_i (b),
        .data_o (b_mag)
    );

    mul_cneg #(.WIDTH(2*WIDTH)) u_prod (
        .neg_i  (neg_q),
        .data_i (acc_q),
        .data_o (prod)
    );

`ifdef MUL_EARLY_OUT_EN
    assign calc_last = (cnt_q == CNT_W'(WIDTH-1)) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign calc_last = (cnt_q == CNT_W'(WIDTH-1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (calc_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                {hi_d, lo_d} = prod;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
